// File: rtl/mult_16bit_if.sv
// Operand/result handshake bundle for the 16x16 shift-and-add multiplier.
// master: the issuing pipeline (drives operands, takes the product).
// slave:  the multiplier (accepts operands, presents the product).
// Signals: in_valid/in_ready + A, B, signed_op on the request side;
//          out_valid/out_ready + result on the response side.
interface mult_16bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        signed_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, A, B, signed_op, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, A, B, signed_op, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mult_16bit.sv
// Purpose: multi-cycle 16x16 -> 32 shift-and-add multiplier (one multiplier bit per cycle).
// Latency: 16 cycles from accept edge to out_valid; one multiply per 18 cycles at full rate.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
// Ports: clk, rst_n (synchronous, active-low), bus (mult_16bit_if.slave).
// Build option: define MULT_SIGNED_EN to honour signed_op (two's-complement multiply);
//   when undefined signed_op is ignored and every multiply is unsigned.
module mult_16bit (
  input logic         clk,
  input logic         rst_n,
  mult_16bit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic [3:0]  count;
  logic [31:0] result_q;
  logic        neg;

  logic        accept;
  logic        last;
  logic        in_rdy;
  logic        out_vld;
  logic [15:0] a_cap;
  logic [15:0] b_cap;
  logic [31:0] partial;
  logic [31:0] sum;
  logic [31:0] final_val;

  // ---------------- operand conditioning at accept ----------------
`ifdef MULT_SIGNED_EN
  logic neg_cap;

  // Signed operands are reduced to magnitudes; -32768 maps to 16'h8000,
  // which is exactly right when treated as unsigned.
  always_comb begin
    a_cap   = (bus.signed_op && bus.A[15]) ? (~bus.A + 16'd1) : bus.A;
    b_cap   = (bus.signed_op && bus.B[15]) ? (~bus.B + 16'd1) : bus.B;
    neg_cap = bus.signed_op & (bus.A[15] ^ bus.B[15]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      neg <= 1'b0;
    else if (accept) neg <= neg_cap;
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = bus.signed_op;
  assign a_cap = bus.A;
  assign b_cap = bus.B;
  assign neg   = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs depend only on registered state (and reset), never on
  // in_valid/out_ready, so the pipeline sees no combinational loop.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = rst_n;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (count == 4'd15) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.result    = result_q;

  // ---------------- datapath ----------------
  // Partial product for the current multiplier bit, weighted by its position.
  assign partial   = {16'b0, mcand & {16{mplier[0]}}} << count;
  assign sum       = acc + partial;
  assign final_val = neg ? (~sum + 32'd1) : sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand    <= 16'h0;
      mplier   <= 16'h0;
      acc      <= 32'h0;
      count    <= 4'h0;
      result_q <= 32'h0;
    end else if (accept) begin
      mcand  <= a_cap;
      mplier <= b_cap;
      acc    <= 32'h0;
      count  <= 4'h0;
    end else if (state == BUSY) begin
      acc    <= sum;
      mplier <= mplier >> 1;
      count  <= count + 4'd1;  // 15 -> 0 coincides with the move to DONE
      if (last) result_q <= final_val;
    end
  end

endmodule

// File: tb/tb_mult_16bit.sv
// Self-checking bench for mult_16bit: directed vectors, randomized operands with
// input scrambling during BUSY, backpressure, mid-operation reset and full-rate issue.
// Works for both builds; the reference model follows MULT_SIGNED_EN.
module tb_mult_16bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mult_16bit_if bus ();

  mult_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference product straight from integer arithmetic.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] ua;
    logic [31:0] ub;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    ua = {16'b0, a};
    ub = {16'b0, b};
`ifdef MULT_SIGNED_EN
    if (s) return 32'(sa * sb);
`endif
    if (s && (sa == sb) && (sa != sa)) return 32'h0;  // never taken; keeps s used in unsigned build
    return ua * ub;
  endfunction

  // Issue one operation and wait for out_valid; optionally scrambles the
  // inputs every cycle while the unit is busy. lat = edges from accept to out_valid.
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input bit scramble, output logic [31:0] res, output int lat);
    int w;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.signed_op = s;
    bus.out_ready = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (scramble) begin
        bus.A         = 16'($urandom);
        bus.B         = 16'($urandom);
        bus.signed_op = 1'($urandom);
        bus.in_valid  = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    res = bus.result;
  endtask

  // Take the product while offering a fresh operand in the same cycle; the
  // unit must return to IDLE rather than accept it.
  task automatic consume();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 16'h5555;
    bus.B         = 16'h3333;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = 16'h0; bus.B = 16'h0;
    bus.signed_op = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [7] = '{16'h00FF, 16'hFFFF, 16'h1234, 16'hFFFD, 16'h8000, 16'hFFFF, 16'h0003};
    logic [15:0] tb [7] = '{16'h0101, 16'hFFFF, 16'h0000, 16'h0005, 16'h8000, 16'hFFFF, 16'h0004};
    logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] res;
    logic [31:0] exp;
    int lat;
    for (int i = 0; i < 7; i++) begin
      exp = model(ta[i], tb[i], ts[i]);
      do_mult(ta[i], tb[i], ts[i], 1'b0, res, lat);
      total++; if (lat != 16) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=16", i, lat); end
      total++; if (res !== exp) begin bad++; $display("FAIL dir_result[%0d] %h*%h s=%b got=%h want=%h", i, ta[i], tb[i], ts[i], res, exp); end
      consume();
      total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
        begin bad++; $display("FAIL dir_after_take[%0d] in_ready=%b out_valid=%b want 1/0", i, bus.in_ready, bus.out_valid); end
    end
    // Unsigned reading of the -3*5 bit pattern regardless of build.
    do_mult(16'hFFFD, 16'h0005, 1'b0, 1'b0, res, lat);
    total++; if (res !== 32'h0004_FFF1) begin bad++; $display("FAIL dir_unsigned_fffd got=%h want=0004fff1", res); end
    consume();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] res;
    logic [31:0] exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      if (i == 0) a = 16'h8000;
      if (i == 1) b = 16'h8000;
      exp = model(a, b, s);
      do_mult(a, b, s, 1'b1, res, lat);
      total++; if (lat != 16 || res !== exp)
        begin bad++; $display("FAIL rand[%0d] %h*%h s=%b got=%h lat=%0d want=%h lat=16", i, a, b, s, res, lat, exp); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [31:0] exp;
    int lat;
    int errs;
    exp = model(16'hBEEF, 16'h1357, 1'b0);
    do_mult(16'hBEEF, 16'h1357, 1'b0, 1'b0, res, lat);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== exp) errs++;
    end
    bus.in_valid = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d want=0 result=%h want=%h", errs, bus.result, exp); end
    consume();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin bad++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    total++; if (bus.result !== exp) begin bad++; $display("FAIL bp_result_kept got=%h want=%h", bus.result, exp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 16'h7777; bus.B = 16'h9999; bus.signed_op = 1'b0;
    @(posedge clk);          // accept edge
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);  // BUSY edges 1..6
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);          // 7th BUSY edge sees reset
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.out_valid !== 1'b0 || bus.result !== 32'h0)
      begin bad++; $display("FAIL midrst_state out_valid=%b result=%h want 0/0", bus.out_valid, bus.result); end
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle in_ready=%b want=1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_output out_valid_cycles=%0d want=0", seen); end
    do_mult(16'h0003, 16'h0004, 1'b0, 1'b0, res, lat);
    total++; if (res !== 32'h0000_000C) begin bad++; $display("FAIL midrst_next got=%h want=0000000c", res); end
    consume();
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    logic [31:0] exp;
    logic [31:0] r1;
    logic [31:0] r2;
    exp = model(16'hA5A5, 16'h0F0F, 1'b1);
    first = -1;
    second = -1;
    r1 = 32'h0;
    r2 = 32'h0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 16'hA5A5; bus.B = 16'h0F0F; bus.signed_op = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && second < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) begin first = c; r1 = bus.result; end
        else begin second = c; r2 = bus.result; end
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (second - first != 18 || first < 0)
      begin bad++; $display("FAIL b2b_period got=%0d want=18", second - first); end
    total++; if (r1 !== exp || r2 !== exp) begin bad++; $display("FAIL b2b_result got=%h,%h want=%h", r1, r2, exp); end
    repeat (20) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
